// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-subset core: one ALU, one unified memory port,
// FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with req/ready memory handshake.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ADDR_W       = 32,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t state, state_nx;

  logic [31:0] pc, ir, a, b, aluout, mdr;
  logic [31:0] rf [32];
  logic        run;
  logic        ill_q;
  logic        trap;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_halt;
  logic op_ok, fn_ok;

  assign is_r    = (op == OP_R);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);
  assign is_halt = (op == OP_HALT);
  assign op_ok   = is_r | is_lw | is_sw | is_beq
                 | is_addi | is_j | is_halt;

  // Memory port is a pure decode of state and registers; run keeps
  // the first fetch out of the cycle in which reset is released.
  logic        xfer;
  logic [31:0] addr32;

  assign mem_req   = run && (state == FETCH || state == MEM);
  assign mem_we    = (state == MEM) && is_sw;
  assign addr32    = (state == MEM) ? {aluout[31:2], 2'b00} : pc;
  assign mem_addr  = mem_req ? addr32[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_we ? b : 32'h0;
  assign xfer      = mem_req && mem_ready;

  assign pc_out  = pc;
  assign halted  = (state == HALT);
  assign illegal = ill_q;

  alu_t        r_f, alu_f;
  logic [31:0] alu_a, alu_b, alu_y;

  always_comb begin
    r_f   = ALU_ADD;
    fn_ok = 1'b1;
    case (funct)
      6'h20:   r_f = ALU_ADD;
      6'h22:   r_f = ALU_SUB;
      6'h24:   r_f = ALU_AND;
      6'h25:   r_f = ALU_OR;
      6'h2A:   r_f = ALU_SLT;
      default: fn_ok = 1'b0;
    endcase
  end

  // Shared ALU: PC+4 in FETCH, branch target in DECODE, operation in EXEC.
  always_comb begin
    alu_a = pc;
    alu_b = 32'd4;
    alu_f = ALU_ADD;
    case (state)
      DECODE: alu_b = {imm_sx[29:0], 2'b00};
      EXEC: begin
        alu_a = a;
        if (is_r) begin
          alu_b = b;
          alu_f = r_f;
        end else if (is_beq) begin
          alu_b = b;
          alu_f = ALU_SUB;
        end else begin
          alu_b = imm_sx;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_f)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    trap     = 1'b0;
    case (state)
      FETCH:
        if (xfer) state_nx = DECODE;
      DECODE:
        if (is_halt) begin
          state_nx = HALT;
        end else if (!op_ok) begin
          if (TRAP_ILLEGAL) begin
            state_nx = HALT;
            trap     = 1'b1;
          end else begin
            state_nx = FETCH;
            retire   = 1'b1;
          end
        end else begin
          state_nx = EXEC;
        end
      EXEC:
        unique case (1'b1)
          is_r:
            if (fn_ok) begin
              state_nx = WB;
            end else if (TRAP_ILLEGAL) begin
              state_nx = HALT;
              trap     = 1'b1;
            end else begin
              state_nx = FETCH;
              retire   = 1'b1;
            end
          is_addi:
            state_nx = WB;
          is_lw, is_sw:
            state_nx = MEM;
          is_beq, is_j: begin
            state_nx = FETCH;
            retire   = 1'b1;
          end
          default:
            state_nx = FETCH;
        endcase
      MEM:
        if (xfer) begin
          if (is_sw) begin
            state_nx = FETCH;
            retire   = 1'b1;
          end else begin
            state_nx = WB;
          end
        end
      WB: begin
        state_nx = FETCH;
        retire   = 1'b1;
      end
      HALT:
        state_nx = HALT;
      default:
        state_nx = FETCH;
    endcase
  end

  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  assign wb_dst  = is_r ? rd : rt;
  assign wb_data = is_lw ? mdr : aluout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      run    <= 1'b0;
      ill_q  <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      if (trap) ill_q <= 1'b1;
      case (state)
        FETCH:
          if (xfer) begin
            ir <= mem_rdata;
            pc <= alu_y;
          end
        DECODE: begin
          a      <= rf[rs];
          b      <= rf[rt];
          aluout <= alu_y;
        end
        EXEC: begin
          if (is_r || is_addi || is_lw || is_sw) aluout <= alu_y;
          if (is_beq && alu_y == 32'h0) pc <= aluout;
          if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        MEM:
          if (xfer && !is_sw) mdr <= mem_rdata;
        WB:
          if (wb_dst != 5'd0) rf[wb_dst] <= wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs against a
// wait-state memory model, hand-computed register and timing results.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc_out;
  logic        retire, halted, illegal;

  always #5 clk = ~clk;

  mips_multicycle #(
    .RESET_PC(32'h0000_0100),
    .ADDR_W(32),
    .TRAP_ILLEGAL(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc_out(pc_out),
    .retire(retire),
    .halted(halted),
    .illegal(illegal)
  );

  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  int          waits = 0;
  int          wcnt;
  logic        stall_en = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  int          cyc = 0;
  int          first_req;
  int          wr_cnt;
  logic [31:0] wr_addr, wr_data;
  int          rq[$];
  logic [31:0] fq[$];

  assign mem_ready = mem_req && !(stall_en && mem_addr == stall_addr)
                     && (wcnt >= waits);
  assign mem_rdata = mem[mem_addr[9:2]];

  // Memory model and event log; the image is reloaded on every reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      wcnt      <= 0;
      first_req <= -1;
      wr_cnt    <= 0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rq.delete();
      fq.delete();
    end else begin
      wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
      if (mem_req && first_req < 0) first_req <= cyc;
      if (retire) rq.push_back(cyc);
      if (mem_req && mem_ready && !mem_we) fq.push_back(mem_addr);
      if (mem_req && mem_ready && mem_we) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs,
                                        logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  task automatic clr();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    prog[addr / 4] = w;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("halt_reached", {31'h0, halted}, 32'h1);
  endtask

  initial begin
    int n;
    // R-type program, 2 wait states on every transfer
    clr();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, enc_i(6'h08, 5'd0, 5'd2, 16'hFFF9));
    put(32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h10C, enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
    put(32'h110, enc_r(5'd1, 5'd2, 5'd5, 6'h24));
    put(32'h114, enc_r(5'd1, 5'd2, 5'd6, 6'h25));
    put(32'h118, enc_r(5'd1, 5'd2, 5'd7, 6'h22));
    put(32'h11C, enc_r(5'd1, 5'd2, 5'd8, 6'h2A));
    put(32'h120, HALT_W);
    waits = 2;

    // Reset state, then first fetch one cycle after release
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_pc", pc_out, 32'h100);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_flags", {29'h0, retire, halted, illegal}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    check("rel_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_addr", mem_addr, 32'h100);
    check("first_we", {31'h0, mem_we}, 32'h0);

    wait_halt(500);
    check("r1", dut.rf[1], 32'h0000_0005);
    check("r2", dut.rf[2], 32'hFFFF_FFF9);
    check("r3_add", dut.rf[3], 32'hFFFF_FFFE);
    check("r4_slt", dut.rf[4], 32'h0000_0001);
    check("r5_and", dut.rf[5], 32'h0000_0001);
    check("r6_or", dut.rf[6], 32'hFFFF_FFFD);
    check("r7_sub", dut.rf[7], 32'h0000_000C);
    check("r8_slt", dut.rf[8], 32'h0000_0000);
    check("rt_retires", rq.size(), 32'd8);
    if (rq.size() == 8) begin
      check("rt_cyc0", rq[0] - first_req + 1, 32'd6);
      for (int i = 1; i < 8; i++)
        check($sformatf("rt_cyc%0d", i), rq[i] - rq[i-1], 32'd6);
    end

    // Store/load round trip, zero waits
    clr();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h108, enc_i(6'h23, 5'd0, 5'd5, 16'd8));
    put(32'h10C, HALT_W);
    waits = 0;
    do_reset();
    wait_halt(200);
    check("sw_count", wr_cnt, 32'd1);
    check("sw_addr", wr_addr, 32'h8);
    check("sw_data", wr_data, 32'h5);
    check("lw_r5", dut.rf[5], 32'h5);
    check("mem_retires", rq.size(), 32'd3);
    if (rq.size() == 3) begin
      check("addi_cyc", rq[0] - first_req + 1, 32'd4);
      check("sw_cyc", rq[1] - rq[0], 32'd4);
      check("lw_cyc", rq[2] - rq[1], 32'd5);
    end

    // Branches and jumps: fetch address trace
    clr();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd2, 16'd1));
    put(32'h104, enc_j(26'h4));
    put(32'h010, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    put(32'h01C, enc_i(6'h04, 5'd0, 5'd2, 16'd5));
    put(32'h020, enc_j(26'h40));
    do_reset();
    n = 0;
    while (fq.size() < 6 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("br_fetches", {31'h0, fq.size() >= 6}, 32'h1);
    if (fq.size() >= 6) begin
      check("br_f0", fq[0], 32'h100);
      check("br_f1", fq[1], 32'h104);
      check("j_target", fq[2], 32'h010);
      check("beq_taken", fq[3], 32'h01C);
      check("beq_not_taken", fq[4], 32'h020);
      check("j_0x40", fq[5], 32'h100);
    end
    if (rq.size() >= 4) begin
      check("beq_t_cyc", rq[2] - rq[1], 32'd3);
      check("beq_n_cyc", rq[3] - rq[2], 32'd3);
    end else begin
      check("br_retires", {31'h0, rq.size() >= 4}, 32'h1);
    end

    // r0 stays zero, halt stops all requests
    clr();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
    put(32'h104, HALT_W);
    do_reset();
    wait_halt(100);
    check("r0_zero", dut.rf[0], 32'h0);
    check("halt_illegal", {31'h0, illegal}, 32'h0);
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_req) n++;
    end
    check("halt_noreq", n, 32'd0);
    check("halt_held", {31'h0, halted}, 32'h1);

    // Illegal opcode 0x3E traps
    clr();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    put(32'h104, 32'hF800_0000);
    do_reset();
    wait_halt(100);
    check("ill_flag", {31'h0, illegal}, 32'h1);
    check("ill_r1", dut.rf[1], 32'h1);
    check("ill_req", {31'h0, mem_req}, 32'h0);

    // Reset while a load is stalled in MEM
    clr();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd3));
    put(32'h104, enc_i(6'h23, 5'd0, 5'd6, 16'd8));
    put(32'h108, HALT_W);
    put(32'h008, 32'h0000_0055);
    stall_en   = 1'b1;
    stall_addr = 32'h8;
    do_reset();
    check("rst_clears_ill", {31'h0, illegal}, 32'h0);
    n = 0;
    while (!(mem_req && mem_addr == 32'h8) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("stall_req", {31'h0, mem_req}, 32'h1);
    check("stall_addr", mem_addr, 32'h8);
    check("stall_r1", dut.rf[1], 32'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req", {31'h0, mem_req}, 32'h0);
    check("mid_rst_pc", pc_out, 32'h100);
    check("mid_rst_r6", dut.rf[6], 32'h0);
    check("mid_rst_r1", dut.rf[1], 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    stall_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
